// File: rtl/fpi2cseq.sv
// I2C byte/bit sequencer below the front-panel register interface.
// Runs up to six opcode fields on an open-drain SCL/SDA pair, stepped by CSTEP.
module fpi2cseq #(
    parameter int DIVIDE = 125
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        CSTEP,
    input  logic        wrcmd,
    input  logic [63:0] command,
    output logic [63:0] comand,
    output logic [63:0] status,
    output logic        sclo,
    output logic        sdao,
    input  logic        sdai
);

    localparam int DW = (DIVIDE > 2) ? $clog2(DIVIDE) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIVIDE - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BIT   = 3'd2,
        S_STOP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     fld_q, fld_d;
    logic [3:0]     bit_q, bit_d;
    logic [1:0]     qtr_q, qtr_d;
    logic [DW-1:0]  div_q, div_d;
    logic [63:0]    comand_q, comand_d;
    logic           busy_q, busy_d;
    logic           ackerr_q, ackerr_d;
    logic           overrun_q, overrun_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [47:0]    rdsr_q, rdsr_d;
    logic           ack_q, ack_d;
    logic           sclo_q, sclo_d;
    logic           sdao_q, sdao_d;
    logic [9:0]     cur_fw_s;
    logic [9:0]     nxt_fw_s;
    logic [9:0]     first_fw_s;
    logic           qend_s;
    logic [1:0]     drv_s;

    function automatic logic [9:0] field_of(input logic [63:0] cmd, input logic [2:0] idx);
        logic [9:0] fw;
        case (idx)
            3'd0:    fw = cmd[59:50];
            3'd1:    fw = cmd[49:40];
            3'd2:    fw = cmd[39:30];
            3'd3:    fw = cmd[29:20];
            3'd4:    fw = cmd[19:10];
            3'd5:    fw = cmd[9:0];
            default: fw = 10'd0;
        endcase
        return fw;
    endfunction

    function automatic state_t field_entry(input logic [9:0] fw);
        state_t st;
        case (fw[9:8])
            2'd0:    st = S_STOP;
            2'd1:    st = S_START;
            default: st = S_BIT;
        endcase
        return st;
    endfunction

    // Pin levels for a sequencer position; {scl, sda}, 1 = released.
    function automatic logic [1:0] bus_drive(input state_t st, input logic [1:0] q,
                                             input logic [3:0] b, input logic [9:0] fw);
        logic       scl;
        logic       sda;
        logic [7:0] d;
        d = fw[7:0];
        case (st)
            S_START: begin
                scl = (q == 2'd1) || (q == 2'd2);
                sda = (q == 2'd0) || (q == 2'd1);
            end
            S_BIT: begin
                scl = q[1];
                if (b == 4'd8) begin
                    sda = (fw[9:8] == 2'd3) ? fw[0] : 1'b1;
                end else begin
                    sda = (fw[9:8] == 2'd3) ? 1'b1 : d[3'd7 - b[2:0]];
                end
            end
            S_STOP: begin
                scl = (q != 2'd0);
                sda = (q == 2'd2);
            end
            default: begin
                scl = 1'b1;
                sda = 1'b1;
            end
        endcase
        return {scl, sda};
    endfunction

    assign cur_fw_s   = field_of(comand_q, fld_q);
    assign first_fw_s = field_of(command, 3'd0);

    // Next-state logic: command acceptance, quarter divider and field sequencing.
    always_comb begin
        state_d   = state_q;
        fld_d     = fld_q;
        bit_d     = bit_q;
        qtr_d     = qtr_q;
        div_d     = div_q;
        comand_d  = comand_q;
        busy_d    = busy_q;
        ackerr_d  = ackerr_q;
        overrun_d = overrun_q;
        cnt_d     = cnt_q;
        rdsr_d    = rdsr_q;
        ack_d     = ack_q;
        nxt_fw_s  = 10'd0;
        qend_s    = 1'b0;

        if (wrcmd && busy_q) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end

        if (wrcmd && !busy_q) begin
            comand_d  = command;
            busy_d    = 1'b1;
            ackerr_d  = 1'b0;
            overrun_d = 1'b0;
            rdsr_d    = 48'd0;
            fld_d     = 3'd0;
            bit_d     = 4'd0;
            qtr_d     = 2'd0;
            div_d     = {DW{1'b0}};
            state_d   = field_entry(first_fw_s);
            cnt_d     = (first_fw_s[9:8] == 2'd0) ? 3'd1 : 3'd0;
        end else if (CSTEP) begin
            if (div_q == DIV_LAST) begin
                qend_s = 1'b1;
            end else begin
                qend_s = 1'b0;
            end
            case (state_q)
                S_START: begin
                    div_d = qend_s ? {DW{1'b0}} : div_q + 1'b1;
                    if (qend_s) begin
                        if (qtr_q == 2'd3) begin
                            state_d = S_BIT;
                            bit_d   = 4'd0;
                            qtr_d   = 2'd0;
                        end else begin
                            qtr_d = qtr_q + 2'd1;
                        end
                    end else begin
                        qtr_d = qtr_q;
                    end
                end
                S_BIT: begin
                    div_d = qend_s ? {DW{1'b0}} : div_q + 1'b1;
                    if (qend_s && (qtr_q == 2'd2)) begin
                        qtr_d = 2'd3;
                        if (bit_q == 4'd8) begin
                            ack_d = sdai;
                        end else if (cur_fw_s[9:8] == 2'd3) begin
                            rdsr_d = {rdsr_q[46:0], sdai};
                        end else begin
                            ack_d = ack_q;
                        end
                    end else if (qend_s && (qtr_q == 2'd3)) begin
                        qtr_d = 2'd0;
                        if (bit_q == 4'd8) begin
                            // Field finished: count it, then stop on NACK or dispatch the next one.
                            cnt_d = cnt_q + 3'd1;
                            fld_d = fld_q + 3'd1;
                            bit_d = 4'd0;
                            if ((cur_fw_s[9:8] != 2'd3) && ack_q) begin
                                ackerr_d = 1'b1;
                                state_d  = S_STOP;
                            end else if (fld_q == 3'd5) begin
                                state_d = S_STOP;
                            end else begin
                                nxt_fw_s = field_of(comand_q, fld_q + 3'd1);
                                state_d  = field_entry(nxt_fw_s);
                                if (nxt_fw_s[9:8] == 2'd0) begin
                                    cnt_d = cnt_q + 3'd2;
                                end else begin
                                    cnt_d = cnt_q + 3'd1;
                                end
                            end
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end else if (qend_s) begin
                        qtr_d = qtr_q + 2'd1;
                    end else begin
                        qtr_d = qtr_q;
                    end
                end
                S_STOP: begin
                    div_d = qend_s ? {DW{1'b0}} : div_q + 1'b1;
                    if (qend_s) begin
                        if (qtr_q == 2'd2) begin
                            state_d = S_DONE;
                            qtr_d   = 2'd0;
                        end else begin
                            qtr_d = qtr_q + 2'd1;
                        end
                    end else begin
                        qtr_d = qtr_q;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        drv_s  = bus_drive(state_d, qtr_d, bit_d, field_of(comand_d, fld_d));
        sclo_d = drv_s[1];
        sdao_d = drv_s[0];
    end

    // State, status and pin registers; RESET returns to an idle, released bus.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            fld_q     <= 3'd0;
            bit_q     <= 4'd0;
            qtr_q     <= 2'd0;
            div_q     <= {DW{1'b0}};
            comand_q  <= 64'd0;
            busy_q    <= 1'b0;
            ackerr_q  <= 1'b0;
            overrun_q <= 1'b0;
            cnt_q     <= 3'd0;
            rdsr_q    <= 48'd0;
            ack_q     <= 1'b0;
            sclo_q    <= 1'b1;
            sdao_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            fld_q     <= fld_d;
            bit_q     <= bit_d;
            qtr_q     <= qtr_d;
            div_q     <= div_d;
            comand_q  <= comand_d;
            busy_q    <= busy_d;
            ackerr_q  <= ackerr_d;
            overrun_q <= overrun_d;
            cnt_q     <= cnt_d;
            rdsr_q    <= rdsr_d;
            ack_q     <= ack_d;
            sclo_q    <= sclo_d;
            sdao_q    <= sdao_d;
        end
    end

    assign comand = comand_q;
    assign status = {busy_q, ackerr_q, overrun_q, 1'b0, 1'b0, cnt_q, 8'd0, rdsr_q};
    assign sclo   = sclo_q;
    assign sdao   = sdao_q;

endmodule

// File: tb/tb_fpi2cseq.sv
// Scoreboard bench for fpi2cseq: a behavioural I2C slave plus a bus monitor
// whose START/byte/STOP events are compared against a queue filled from a command model.
module tb_fpi2cseq;

    localparam int DIV = 4;
    localparam logic [9:0] EV_START = 10'h200;
    localparam logic [9:0] EV_STOP  = 10'h300;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        CSTEP = 1'b1;
    logic        wrcmd = 1'b0;
    logic [63:0] command = 64'd0;
    logic [63:0] comand;
    logic [63:0] status;
    logic        sclo;
    logic        sdao;
    logic        sdai;
    logic        slv_sda = 1'b1;

    assign sdai = sdao & slv_sda;

    fpi2cseq #(.DIVIDE(DIV)) dut (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .CSTEP   (CSTEP),
        .wrcmd   (wrcmd),
        .command (command),
        .comand  (comand),
        .status  (status),
        .sclo    (sclo),
        .sdao    (sdao),
        .sdai    (sdai)
    );

    always #5 CLOCK = ~CLOCK;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0]  expq [$];
    logic        slv_isrd [6];
    logic [7:0]  slv_rd   [6];
    logic        slv_ack  [6];
    logic [63:0] exp_status;
    int          exp_busy;
    int          exp_rises;

    int          cstep_mode = 0;
    int          phase = 0;
    logic        mon_en = 1'b0;
    int          r_cnt = 0;
    int          bits = 0;
    logic [8:0]  acc = 9'd0;
    int          rises = 0;
    int          busy_cyc = 0;
    int          freeze_viol = 0;
    logic        prev_scl = 1'b1, prev_sda = 1'b1, prev_busy = 1'b0, prev_cstep = 1'b1;
    logic        prev_sclo = 1'b1, prev_sdao = 1'b1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic sb_event(input logic [9:0] ev);
        logic [9:0] e;
        if (expq.size() == 0) begin
            check_eq("sb_extra", {54'd0, ev}, 64'h3FF);
        end else begin
            e = expq.pop_front();
            check_eq("sb_event", {54'd0, ev}, {54'd0, e});
        end
    endtask

    function automatic logic slave_bit(input int r);
        int b;
        int p;
        b = r / 9;
        p = r % 9;
        if (b > 5) return 1'b1;
        if (slv_isrd[b]) return (p < 8) ? slv_rd[b][7-p] : 1'b1;
        return (p == 8) ? slv_ack[b] : 1'b1;
    endfunction

    // Slave, bus monitor, CSTEP generator and freeze watcher, all away from the active edge.
    always @(negedge CLOCK) begin
        logic scl;
        logic sda;
        logic cs;
        scl = sclo;
        sda = sdai;
        if (cstep_mode == 1 && prev_busy && !prev_cstep && (sclo !== prev_sclo || sdao !== prev_sdao))
            freeze_viol++;
        if (!mon_en) begin
            r_cnt = 0;
            bits  = 0;
        end else if (scl && !prev_scl) begin
            rises++;
            r_cnt++;
            acc = {acc[7:0], sda};
            bits++;
            if (bits == 9) begin
                bits = 0;
                sb_event({1'b0, acc});
            end
        end else if (scl && prev_scl && prev_sda && !sda) begin
            r_cnt = 0;
            bits  = 0;
            sb_event(EV_START);
        end else if (scl && prev_scl && !prev_sda && sda) begin
            bits = 0;
            sb_event(EV_STOP);
        end
        if (!mon_en) slv_sda = 1'b1;
        else if (!scl) slv_sda = slave_bit(r_cnt);
        cs = (cstep_mode == 0) ? 1'b1 : (phase == 0);
        phase = (phase == 9) ? 0 : phase + 1;
        CSTEP = cs;
        if (status[63] && cs) busy_cyc++;
        prev_scl   = scl;
        prev_sda   = sda;
        prev_busy  = status[63];
        prev_cstep = cs;
        prev_sclo  = sclo;
        prev_sdao  = sdao;
    end

    task automatic set_slave();
        for (int i = 0; i < 6; i++) begin
            slv_isrd[i] = 1'b0;
            slv_rd[i]   = 8'h00;
            slv_ack[i]  = 1'b0;
        end
    endtask

    // Reference model: bus events, final status, busy length and SCL rises for one command.
    task automatic expect_cmd(input logic [63:0] c, input logic ovr);
        logic [9:0]  f;
        logic        ae;
        logic [3:0]  cnt;
        logic [47:0] rd;
        logic        a;
        int          nb;
        int          starts;
        int          bidx;
        ae = 1'b0; cnt = 4'd0; rd = 48'd0; nb = 0; starts = 0; bidx = 0;
        for (int i = 0; i < 6; i++) begin
            f = c[59 - 10*i -: 10];
            cnt++;
            if (f[9:8] == 2'd0) break;
            if (f[9:8] == 2'd1) begin
                expq.push_back(EV_START);
                starts++;
                bidx = 0;
            end
            nb++;
            if (f[9:8] == 2'd3) begin
                expq.push_back({1'b0, slv_rd[bidx], f[0]});
                rd = {rd[39:0], slv_rd[bidx]};
                bidx++;
            end else begin
                a = slv_ack[bidx];
                expq.push_back({1'b0, f[7:0], a});
                bidx++;
                if (a) begin
                    ae = 1'b1;
                    break;
                end
            end
        end
        expq.push_back(EV_STOP);
        exp_status = {1'b0, ae, ovr, 1'b0, cnt, 8'h00, rd};
        exp_busy   = DIV * (4*starts + 36*nb + 3) + 1;
        exp_rises  = starts + 9*nb + 1;
    endtask

    task automatic start_cmd(input logic [63:0] c);
        @(negedge CLOCK);
        command  = c;
        wrcmd    = 1'b1;
        rises    = 0;
        busy_cyc = 0;
        @(negedge CLOCK);
        wrcmd   = 1'b0;
        command = 64'd0;
        check_eq("accept_status", status, {1'b1, 63'd0});
    endtask

    task automatic run_cmd(input logic [63:0] c, input logic inject);
        expect_cmd(c, inject);
        start_cmd(c);
        if (inject) begin
            repeat (60) @(negedge CLOCK);
            command = ~c;
            wrcmd   = 1'b1;
            @(negedge CLOCK);
            wrcmd   = 1'b0;
            check_eq("overrun_flag", {63'd0, status[61]}, 64'd1);
            check_eq("overrun_comand", comand, c);
        end
        for (int k = 0; k < 20000 && status[63]; k++) @(negedge CLOCK);
        check_eq("idle_timeout", {63'd0, status[63]}, 64'd0);
        check_eq("sb_left", expq.size(), 64'd0);
        check_eq("status", status, exp_status);
        check_eq("busy_cycles", busy_cyc, exp_busy);
        check_eq("scl_rises", rises, exp_rises);
        check_eq("comand", comand, c);
        check_eq("bus_idle", {62'd0, sclo, sdao}, 64'd3);
    endtask

    initial begin
        logic [63:0] c1, c2, c3, c4;
        c1 = {4'h0, 10'h1A0, 10'h255, 10'h000, 10'h000, 10'h000, 10'h000};
        c2 = {4'h0, 10'h1A1, 10'h301, 10'h211, 10'h222, 10'h233, 10'h244};
        c3 = {4'hF, 10'h1A2, 10'h211, 10'h000, 10'h000, 10'h000, 10'h000};
        c4 = {4'h0, 10'h1B0, 10'h2C3, 10'h000, 10'h000, 10'h000, 10'h000};
        set_slave();

        RESET = 1'b1;
        repeat (3) @(negedge CLOCK);
        check_eq("rst_sclo", {63'd0, sclo}, 64'd1);
        check_eq("rst_sdao", {63'd0, sdao}, 64'd1);
        check_eq("rst_status", status, 64'd0);
        check_eq("rst_comand", comand, 64'd0);
        RESET  = 1'b0;
        mon_en = 1'b1;
        repeat (3) @(negedge CLOCK);

        // two writes, slave ACKs
        run_cmd(c1, 1'b0);

        // address then read with NACK, then four writes to the end of the command
        set_slave();
        slv_isrd[1] = 1'b1;
        slv_rd[1]   = 8'h3C;
        run_cmd(c2, 1'b0);
        check_eq("read_byte", {56'd0, status[7:0]}, 64'h3C);

        // slave NACKs the first byte
        set_slave();
        slv_ack[0] = 1'b1;
        run_cmd(c3, 1'b0);

        // overrun while busy
        set_slave();
        run_cmd(c4, 1'b1);

        // single-step via CSTEP every 10 cycles; accept also clears overrun
        @(negedge CLOCK);
        cstep_mode  = 1;
        freeze_viol = 0;
        run_cmd(c1, 1'b0);
        check_eq("freeze", freeze_viol, 64'd0);
        @(negedge CLOCK);
        cstep_mode = 0;
        repeat (3) @(negedge CLOCK);

        // reset mid-byte, then a clean rerun
        expect_cmd(c1, 1'b0);
        start_cmd(c1);
        repeat (60) @(negedge CLOCK);
        mon_en = 1'b0;
        RESET  = 1'b1;
        @(negedge CLOCK);
        RESET = 1'b0;
        check_eq("mid_rst_sclo", {63'd0, sclo}, 64'd1);
        check_eq("mid_rst_sdao", {63'd0, sdao}, 64'd1);
        check_eq("mid_rst_status", status, 64'd0);
        check_eq("mid_rst_comand", comand, 64'd0);
        expq.delete();
        repeat (5) @(negedge CLOCK);
        mon_en = 1'b1;
        repeat (2) @(negedge CLOCK);
        run_cmd(c1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
